// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage -- third stage of the 16-bit pipelined CPU.
//
// Takes the decoded instruction, its PC and the operand bundle from decode,
// performs the ALU operation, address generation or branch/jump resolution,
// and holds the outcome in a registered result bundle for the memory stage
// (valid/ready handshake, one cycle latency). Taken branches and jumps raise
// a one-cycle REDIRECT pulse with the new fetch PC.
//
// Optional feature macro: EXEC_FORWARD_EN
//   defined   -> an ALU op or BEQ accepted directly behind a held ALU op or
//                ADDI takes the held RESULT in place of stale operands.
//   undefined -> operands are used exactly as delivered by decode.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   INVALID / INREADY        decode-side handshake
//   IRIN, PCIN               instruction word and its PC
//   DATAIN1..DATAIN3         operand bundle
//   OUTVALID / OUTREADY      memory-side handshake
//   IROUT, PCOUT             registered instruction and PC
//   RESULT                   ALU result or LW/SW address
//   STOREDATA                SW store data (0 otherwise)
//   DESTREG, WILLWRITE       held destination and register-write flag
//   LOADPENDING              held instruction is LW
//   REDIRECT, REDIRECTPC     one-cycle redirect pulse and target
// ---------------------------------------------------------------------------
module execute_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INVALID,
    output logic        INREADY,
    input  logic [15:0] IRIN,
    input  logic [15:0] PCIN,
    input  logic [15:0] DATAIN1,
    input  logic [15:0] DATAIN2,
    input  logic [15:0] DATAIN3,
    output logic        OUTVALID,
    input  logic        OUTREADY,
    output logic [15:0] IROUT,
    output logic [15:0] PCOUT,
    output logic [15:0] RESULT,
    output logic [15:0] STOREDATA,
    output logic [3:0]  DESTREG,
    output logic        WILLWRITE,
    output logic        LOADPENDING,
    output logic        REDIRECT,
    output logic [15:0] REDIRECTPC
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JUMP = 4'hA;

    logic        valid_reg;
    logic [15:0] ir_reg;
    logic [15:0] pc_reg;
    logic [15:0] result_reg;
    logic [15:0] storedata_reg;
    logic [3:0]  destreg_reg;
    logic        willwrite_reg;
    logic        loadpending_reg;
    logic        redirect_reg;
    logic [15:0] redirectpc_reg;

    logic [15:0] result_next;
    logic [15:0] storedata_next;
    logic [3:0]  destreg_next;
    logic        willwrite_next;
    logic        loadpending_next;
    logic        taken_next;
    logic [15:0] redirectpc_next;

    logic [15:0] opnd1;
    logic [15:0] opnd2;
    logic [15:0] opnd3;
    logic [3:0]  in_op;
    logic        accept;

    assign in_op   = IRIN[15:12];
    assign INREADY = ~valid_reg | OUTREADY;
    // The instruction right behind a taken branch/jump is wrong-path.
    assign accept  = INVALID & INREADY & ~redirect_reg;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_OR) || (op == OP_AND) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

`ifdef EXEC_FORWARD_EN
    // Only ALU ops and ADDI have their value in RESULT; LW holds an address.
    logic held_fwd;
    assign held_fwd = valid_reg & willwrite_reg &
                      (is_alu(ir_reg[15:12]) | (ir_reg[15:12] == OP_ADDI));

    always_comb begin
        opnd1 = DATAIN1;
        opnd2 = DATAIN2;
        opnd3 = DATAIN3;
        if (held_fwd) begin
            if (is_alu(in_op)) begin
                if (destreg_reg == IRIN[7:4]) opnd2 = result_reg;
                if (destreg_reg == IRIN[3:0]) opnd3 = result_reg;
            end else if (in_op == OP_BEQ) begin
                if (destreg_reg == IRIN[11:8]) opnd1 = result_reg;
                if (destreg_reg == IRIN[7:4])  opnd2 = result_reg;
            end
        end
    end
`else
    assign opnd1 = DATAIN1;
    assign opnd2 = DATAIN2;
    assign opnd3 = DATAIN3;
`endif

    always_comb begin
        result_next      = 16'd0;
        storedata_next   = 16'd0;
        destreg_next     = 4'd0;
        willwrite_next   = 1'b0;
        loadpending_next = 1'b0;
        taken_next       = 1'b0;
        redirectpc_next  = 16'd0;
        if (is_alu(in_op)) begin
            destreg_next   = opnd1[3:0];
            willwrite_next = 1'b1;
        end
        case (in_op)
            OP_ADD: result_next = opnd2 + opnd3;
            OP_OR:  result_next = opnd2 | opnd3;
            OP_AND: result_next = opnd2 & opnd3;
            OP_SUB: result_next = opnd2 - opnd3;
            OP_SLT: result_next = {15'd0, $signed(opnd2) < $signed(opnd3)};
            OP_ADDI, OP_LW: begin
                result_next      = opnd2;
                destreg_next     = opnd1[3:0];
                willwrite_next   = 1'b1;
                loadpending_next = (in_op == OP_LW);
            end
            OP_SW: begin
                result_next    = opnd2;
                storedata_next = opnd1;
            end
            OP_BEQ: begin
                taken_next      = (opnd1 == opnd2);
                redirectpc_next = PCIN + 16'd1 + {{12{IRIN[3]}}, IRIN[3:0]};
            end
            OP_JUMP: begin
                taken_next      = 1'b1;
                redirectpc_next = {8'd0, opnd1[7:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_reg       <= 1'b0;
            ir_reg          <= 16'd0;
            pc_reg          <= 16'd0;
            result_reg      <= 16'd0;
            storedata_reg   <= 16'd0;
            destreg_reg     <= 4'd0;
            willwrite_reg   <= 1'b0;
            loadpending_reg <= 1'b0;
            redirect_reg    <= 1'b0;
            redirectpc_reg  <= 16'd0;
        end else begin
            // Redirect is a pulse: only the first cycle in the register.
            redirect_reg <= 1'b0;
            if (accept) begin
                valid_reg       <= 1'b1;
                ir_reg          <= IRIN;
                pc_reg          <= PCIN;
                result_reg      <= result_next;
                storedata_reg   <= storedata_next;
                destreg_reg     <= destreg_next;
                willwrite_reg   <= willwrite_next;
                loadpending_reg <= loadpending_next;
                redirect_reg    <= taken_next;
                if (taken_next)
                    redirectpc_reg <= redirectpc_next;
            end else if (OUTREADY) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign OUTVALID    = valid_reg;
    assign IROUT       = ir_reg;
    assign PCOUT       = pc_reg;
    assign RESULT      = result_reg;
    assign STOREDATA   = storedata_reg;
    // Hazard info describes only a bundle that is actually present.
    assign DESTREG     = valid_reg ? destreg_reg : 4'd0;
    assign WILLWRITE   = valid_reg & willwrite_reg;
    assign LOADPENDING = valid_reg & loadpending_reg;
    assign REDIRECT    = redirect_reg;
    assign REDIRECTPC  = redirectpc_reg;

endmodule
